// File: rtl/nn_pkg.sv
// Shared types and fixed-point helpers for the sequential NN layer controllers.
package nn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_MAC, ST_DRAIN, ST_WRITE, ST_DONE
    } dense_seq_state_t;

    // One guard bit above the worst-case sum of MAX_N full products plus bias.
    function automatic int acc_width(input int width, input int max_n);
        return 2 * width + $clog2(max_n) + 1;
    endfunction

    function automatic longint fxp_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint fxp_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/fxp_requant.sv
// Requantise a full-precision accumulator: >>> FRAC, optional ReLU, narrow to WIDTH.
// DENSE_SEQ_SAT_EN selects saturating narrowing; otherwise the low WIDTH bits are kept.
module fxp_requant
    import nn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 43
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic             relu_i,
    output logic [WIDTH-1:0] y_o
);

    logic signed [ACC_W-1:0] sh;

    always_comb begin
        sh = $signed(acc_i) >>> FRAC;
        if (relu_i && sh[ACC_W-1]) sh = '0;
    end

`ifdef DENSE_SEQ_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(fxp_max(WIDTH));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(fxp_min(WIDTH));

    always_comb begin
        if (sh > SAT_HI)      y_o = SAT_HI[WIDTH-1:0];
        else if (sh < SAT_LO) y_o = SAT_LO[WIDTH-1:0];
        else                  y_o = sh[WIDTH-1:0];
    end
`else
    logic unused_hi;
    assign unused_hi = ^sh[ACC_W-1:WIDTH];
    assign y_o       = sh[WIDTH-1:0];
`endif

endmodule

// File: rtl/dense_seq_ctrl.sv
// Sequential dense-layer scheduler on one shared MAC: y[m] = requant(b[m] + sum_n w[m*N+n]*x[n]).
// Build with DENSE_SEQ_SAT_EN for saturating output narrowing (default wraps).
module dense_seq_ctrl
    import nn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int MAX_N = 784,
    parameter int MAX_M = 128,
    parameter int W_AW  = 17,
    parameter int A_AW  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [A_AW-1:0]  cfg_n,
    input  logic [A_AW-1:0]  cfg_m,
    input  logic             cfg_relu,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             w_rd_en,
    output logic [W_AW-1:0]  w_rd_addr,
    input  logic [WIDTH-1:0] w_rd_data,
    output logic             x_rd_en,
    output logic [A_AW-1:0]  x_rd_addr,
    input  logic [WIDTH-1:0] x_rd_data,
    output logic             b_rd_en,
    output logic [A_AW-1:0]  b_rd_addr,
    input  logic [WIDTH-1:0] b_rd_data,
    output logic             y_we,
    output logic [A_AW-1:0]  y_addr,
    output logic [WIDTH-1:0] y_data
);

    localparam int              ACC_W   = acc_width(WIDTH, MAX_N);
    localparam logic [A_AW-1:0] MAX_N_A = A_AW'(MAX_N);
    localparam logic [A_AW-1:0] MAX_M_A = A_AW'(MAX_M);

    dense_seq_state_t state_q, state_d;
    logic [A_AW-1:0]  cfg_n_q, cfg_n_d, cfg_m_q, cfg_m_d, n_q, n_d, m_q, m_d;
    logic             relu_q, relu_d;
    logic [W_AW-1:0]  wa_q, wa_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             rd_en_q, rd_en_d, b_en_q, b_en_d, y_we_q, y_we_d;
    logic [WIDTH-1:0] y_data_q, y_data_d, rq;

    logic [2*WIDTH-1:0] w_ext, x_ext, prod;
    logic [ACC_W-1:0]   prod_ext, bias_ext;

    always_comb begin
        w_ext    = {{WIDTH{w_rd_data[WIDTH-1]}}, w_rd_data};
        x_ext    = {{WIDTH{x_rd_data[WIDTH-1]}}, x_rd_data};
        prod     = w_ext * x_ext;
        prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        bias_ext = {{(ACC_W-WIDTH){b_rd_data[WIDTH-1]}}, b_rd_data} << FRAC;
    end

    // Read data lags its address by one cycle, so MAC step n consumes the product of read n-1.
    always_comb begin
        state_d = state_q;
        cfg_n_d = cfg_n_q;
        cfg_m_d = cfg_m_q;
        relu_d  = relu_q;
        n_d     = n_q;
        m_d     = m_q;
        wa_d    = wa_q;
        acc_d   = acc_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                if (cfg_n == '0 || cfg_m == '0 || cfg_n > MAX_N_A || cfg_m > MAX_M_A) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                    cfg_n_d = cfg_n;
                    cfg_m_d = cfg_m;
                    relu_d  = cfg_relu;
                    m_d     = '0;
                    wa_d    = '0;
                end
            end
            ST_LOAD: begin
                state_d = ST_MAC;
                n_d     = '0;
                acc_d   = '0;
            end
            ST_MAC: begin
                acc_d = (n_q == '0) ? bias_ext : acc_q + prod_ext;
                wa_d  = wa_q + W_AW'(1);
                if (n_q == cfg_n_q - A_AW'(1)) state_d = ST_DRAIN;
                else                           n_d     = n_q + A_AW'(1);
            end
            ST_DRAIN: begin
                acc_d   = acc_q + prod_ext;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (m_q == cfg_m_q - A_AW'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    m_d     = m_q + A_AW'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    fxp_requant #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_requant (
        .acc_i  (acc_d),
        .relu_i (relu_q),
        .y_o    (rq)
    );

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        rd_en_d  = (state_d == ST_MAC);
        b_en_d   = (state_d == ST_LOAD);
        y_we_d   = (state_d == ST_WRITE);
        done_d   = (state_d == ST_DONE);
        busy_d   = (state_d != ST_IDLE);
        y_data_d = y_we_d ? rq : y_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cfg_n_q  <= '0;
            cfg_m_q  <= '0;
            relu_q   <= 1'b0;
            n_q      <= '0;
            m_q      <= '0;
            wa_q     <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            b_en_q   <= 1'b0;
            y_we_q   <= 1'b0;
            y_data_q <= '0;
        end else begin
            state_q  <= state_d;
            cfg_n_q  <= cfg_n_d;
            cfg_m_q  <= cfg_m_d;
            relu_q   <= relu_d;
            n_q      <= n_d;
            m_q      <= m_d;
            wa_q     <= wa_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rd_en_q  <= rd_en_d;
            b_en_q   <= b_en_d;
            y_we_q   <= y_we_d;
            y_data_q <= y_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign w_rd_en   = rd_en_q;
    assign x_rd_en   = rd_en_q;
    assign w_rd_addr = wa_q;
    assign x_rd_addr = n_q;
    assign b_rd_en   = b_en_q;
    assign b_rd_addr = m_q;
    assign y_we      = y_we_q;
    assign y_addr    = m_q;
    assign y_data    = y_data_q;

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Bench for dense_seq_ctrl: vector table with 1-cycle memory models and a write scoreboard.
module tb_dense_seq_ctrl;

    logic        clk, rst, start, cfg_relu;
    logic [9:0]  cfg_n, cfg_m;
    logic        busy, done, err, w_rd_en, x_rd_en, b_rd_en, y_we;
    logic [16:0] w_rd_addr;
    logic [9:0]  x_rd_addr, b_rd_addr, y_addr;
    logic [15:0] w_rd_data, x_rd_data, b_rd_data, y_data;

    dense_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_relu(cfg_relu),
        .busy(busy), .done(done), .err(err),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .y_we(y_we), .y_addr(y_addr), .y_data(y_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [15:0] wmem [0:1023];
    logic [15:0] xmem [0:1023];
    logic [15:0] bmem [0:1023];

    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= wmem[w_rd_addr[9:0]];
        if (x_rd_en) x_rd_data <= xmem[x_rd_addr];
        if (b_rd_en) b_rd_data <= bmem[b_rd_addr];
    end

    typedef struct {
        int  n, m, xstart, rst_cyc, exp_done, exp_dones;
        bit  relu, exp_err, use_const;
        logic [15:0][15:0] w;
        logic [3:0][15:0]  x, b, y;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    vec_t vec [10];
    wr_t  exp_q [$];
    int   total = 0, bad = 0;
    int   rel, dones, done_rel, acts, wreads;
    logic done_err;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One cycle: advance to the sampling edge and score whatever the DUT presents.
    task automatic step();
        wr_t e;
        @(negedge clk);
        rel++;
        if (w_rd_en) wreads++;
        if (w_rd_en || x_rd_en || b_rd_en || y_we) acts++;
        if (done) begin
            dones++;
            done_rel = rel;
            done_err = err;
        end
        if (y_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL y_unexpected actual=addr %0d data %0h required=no write", y_addr, y_data);
            end else begin
                e = exp_q.pop_front();
                chk("y_write", 80'({y_addr, y_data}), 80'({e.addr, e.data}));
            end
        end
    endtask

    function automatic logic [15:0] ref_y(input int n, input int m, input bit relu);
        longint acc;
        acc = longint'($signed(bmem[m])) * 256;
        for (int k = 0; k < n; k++)
            acc += longint'($signed(wmem[m*n+k])) * longint'($signed(xmem[k]));
        acc = acc >>> 8;
        if (relu && acc < 0) acc = 0;
`ifdef DENSE_SEQ_SAT_EN
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
`endif
        return acc[15:0];
    endfunction

    function automatic vec_t mk(input int n, input int m, input bit relu, input int ed,
                                input int nd, input bit ee, input logic [15:0] wf,
                                input logic [15:0] xf, input logic [15:0] bf);
        vec_t v;
        v.n = n; v.m = m; v.relu = relu; v.exp_done = ed; v.exp_dones = nd; v.exp_err = ee;
        v.xstart = 0; v.rst_cyc = 0; v.use_const = 1'b0;
        for (int i = 0; i < 16; i++) v.w[i] = wf;
        for (int i = 0; i < 4; i++) begin
            v.x[i] = xf; v.b[i] = bf; v.y[i] = '0;
        end
        return v;
    endfunction

    initial begin
        vec_t v;
        wr_t  e;
        int   limit;

        vec[0] = mk(2, 1, 0, 6, 1, 0, 16'd256, 16'd512, 16'd128);
        vec[0].x[1] = 16'd384; vec[0].use_const = 1; vec[0].y[0] = 16'd1024;
        vec[1] = mk(1, 2, 1, 9, 1, 0, 16'd256, 16'd256, 16'd0);
        vec[1].w[1] = 16'hFE00; vec[1].use_const = 1; vec[1].y[0] = 16'd256; vec[1].y[1] = 16'd0;
        vec[2] = vec[1]; vec[2].relu = 0; vec[2].y[1] = 16'hFE00;
        vec[3] = mk(4, 1, 0, 8, 1, 0, 16'h7FFF, 16'h7FFF, 16'd0);
        vec[3].use_const = 1;
`ifdef DENSE_SEQ_SAT_EN
        vec[3].y[0] = 16'h7FFF;
`else
        vec[3].y[0] = 16'hFC00;
`endif
        vec[4] = mk(2, 0, 0, 1, 1, 1, 16'd1, 16'd1, 16'd1);
        vec[5] = mk(785, 1, 0, 1, 1, 1, 16'd1, 16'd1, 16'd1);
        vec[6] = mk(3, 4, 0, 25, 1, 0, 16'd0, 16'd0, 16'd0);
        for (int i = 0; i < 16; i++) vec[6].w[i] = 16'(i * 300 - 2000);
        for (int i = 0; i < 4; i++) begin
            vec[6].x[i] = 16'(i * 500 - 700);
            vec[6].b[i] = 16'(i * 1000 - 1500);
        end
        vec[6].xstart = 5;
        vec[7] = vec[6]; vec[7].xstart = 0; vec[7].rst_cyc = 10; vec[7].exp_dones = 0;
        vec[8] = vec[6]; vec[8].xstart = 0; vec[8].relu = 1;
        vec[9] = mk(784, 1, 0, 788, 1, 0, 16'h0100, 16'h0100, 16'd0);

        rst = 1'b1; start = 1'b0; cfg_n = '0; cfg_m = '0; cfg_relu = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 80'({busy, done, err, w_rd_en, x_rd_en, b_rd_en, y_we, w_rd_addr,
                                 x_rd_addr, b_rd_addr, y_addr, y_data}), 80'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            v = vec[i];
            for (int a = 0; a < 1024; a++) begin
                wmem[a] = v.w[a % 16];
                xmem[a] = v.x[a % 4];
                bmem[a] = v.b[a % 4];
            end
            exp_q.delete();
            if (!v.exp_err)
                for (int k = 0; k < v.m; k++)
                    if (v.rst_cyc == 0 || (k + 1) * (v.n + 3) < v.rst_cyc) begin
                        e.addr = 10'(k);
                        e.data = v.use_const ? v.y[k] : ref_y(v.n, k, v.relu);
                        exp_q.push_back(e);
                    end

            cfg_n = 10'(v.n); cfg_m = 10'(v.m); cfg_relu = v.relu; start = 1'b1;
            rel = 0; dones = 0; done_rel = -1; done_err = 1'b0; acts = 0; wreads = 0;
            limit = v.m * (v.n + 3) + 12;
            while (rel < limit) begin
                step();
                start = (rel == v.xstart);
                if (rel == v.xstart) begin
                    cfg_m = 10'd1; cfg_n = 10'd1;
                end
                if (v.rst_cyc != 0 && rel == v.rst_cyc) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_async", 80'({busy, done, err, w_rd_en, x_rd_en, b_rd_en, y_we,
                                          w_rd_addr, x_rd_addr, b_rd_addr, y_addr, y_data}), 80'(0));
                end
                if (v.rst_cyc != 0 && rel == v.rst_cyc + 2) rst = 1'b0;
            end

            chk($sformatf("v%0d_done_count", i), 80'(dones), 80'(v.exp_dones));
            if (v.exp_dones != 0) begin
                chk($sformatf("v%0d_done_cycle", i), 80'(done_rel), 80'(v.exp_done));
                chk($sformatf("v%0d_err", i), 80'(done_err), 80'(v.exp_err));
            end
            if (v.exp_err)
                chk($sformatf("v%0d_no_traffic", i), 80'(acts), 80'(0));
            else if (v.rst_cyc == 0)
                chk($sformatf("v%0d_w_reads", i), 80'(wreads), 80'(v.n * v.m));
            chk($sformatf("v%0d_writes_left", i), 80'(exp_q.size()), 80'(0));
            chk($sformatf("v%0d_idle_busy", i), 80'(busy), 80'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dense_seq_ctrl.md
Name: dense_seq_ctrl

Overview:
Sequential scheduler for one fully-connected layer on a single shared multiply-accumulate unit. It replaces the fully-parallel combinational dense+ReLU path when area matters. For each output neuron it walks weight, bias and activation memories, accumulates in full precision, then requantises, optionally applies ReLU and writes the result. A top-level network sequencer calls it once per layer, swapping activation buffers between calls.

Parameters:
WIDTH, 16, data word width (signed Q(WIDTH-FRAC).FRAC)
FRAC, 8, fractional bits
MAX_N, 784, max inputs per neuron
MAX_M, 128, max neurons per layer
W_AW, 17, weight memory address width (>= clog2(MAX_N*MAX_M))
A_AW, 10, activation/bias/output address width (>= clog2(max(MAX_N,MAX_M)))

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  launch pulse; sampled only in IDLE
cfg_n  in  A_AW  inputs per neuron N, latched at start
cfg_m  in  A_AW  neurons M, latched at start
cfg_relu  in  1  apply ReLU to outputs, latched at start
busy  out  1  high from the cycle after start is accepted until DONE inclusive
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = rejected config
w_rd_en / w_rd_addr  out  1 / W_AW  weight read; addr = m*N + n
w_rd_data  in  WIDTH  weight data, 1-cycle read latency
x_rd_en / x_rd_addr  out  1 / A_AW  activation read; addr = n
x_rd_data  in  WIDTH  activation data, 1-cycle latency
b_rd_en / b_rd_addr  out  1 / A_AW  bias read; addr = m
b_rd_data  in  WIDTH  bias data, 1-cycle latency
y_we / y_addr / y_data  out  1 / A_AW / WIDTH  result write, addr = m

Behaviour:
- Reset: state IDLE. busy, done, err, all *_en, y_we = 0. All addresses and y_data = 0. Counters and accumulator cleared.
- States: IDLE, LOAD, MAC, DRAIN, WRITE, DONE.
- IDLE: on start with cfg_n==0, cfg_m==0, cfg_n>MAX_N or cfg_m>MAX_M -> DONE with err=1 and no memory traffic. Otherwise latch cfg -> LOAD with m=0.
- LOAD (1 cycle): b_rd_en=1, b_rd_addr=m, acc cleared.
- MAC (N cycles, n=0..N-1): w_rd_en=x_rd_en=1, addresses as above.
  - Cycle n=0: acc <= sext(bias)<<FRAC.
  - Cycles n>=1: acc += w[n-1]*x[n-1] as a full 2*WIDTH signed product.
- DRAIN (1 cycle): acc += w[N-1]*x[N-1]. No reads issued.
- WRITE (1 cycle): y_we=1, y_addr=m, y_data=requant(acc). If m==M-1 -> DONE, else m++ -> LOAD.
- DONE (1 cycle): done=1; err as decided; busy=1 -> IDLE.
- Latency: with start accepted at cycle 0, done is high at cycle M*(N+3)+1. Throughput is N+3 cycles per neuron.
- Accumulator width is ACC_W = 2*WIDTH + clog2(MAX_N) + 1. Overflow cannot occur.
- requant: arithmetic shift right by FRAC (truncation toward -inf), then ReLU if cfg_relu (negative -> 0), then narrowing to WIDTH (see Optional Feature).
- Read enables are low in every state except those listed. Memories must not be read outside MAC/LOAD.
- start while busy is ignored; config changes while busy are ignored.
- rst mid-operation aborts immediately to IDLE. No done pulse, no further writes.

Optional Feature:
Macro DENSE_SEQ_SAT_EN.
- Defined: narrowing saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Undefined: narrowing keeps the low WIDTH bits (two's-complement wrap), matching the existing combinational dense path bit-for-bit.

Decomposition:
- Package nn_pkg: state enum dense_seq_state_t; localparam function acc_width(WIDTH, MAX_N); shared fixed-point saturation limits.
- One sub-module, fxp_requant: combinational shift, ReLU and narrow, parameterised by WIDTH, FRAC and ACC_W. It is reused by future layer controllers.

Test Plan:
- N=2, M=1: w=[256,256], x=[512,384], b=128, relu=0 -> one write y[0]=1024; done high at cycle 6, err=0.
- N=1, M=2: w=[256,-512], x=[256], b=[0,0], relu=1 -> y[0]=256, y[1]=0. With relu=0, y[1]=0xFE00; done at cycle 9.
- N=4, M=1, all w=x=0x7FFF, b=0 -> SAT_EN: y=0x7FFF. Without: y = low 16 bits of (4*0x3FFF0001)>>>8.
- start with cfg_m=0 -> done+err at cycle 1, no *_en or y_we ever asserted. Also with cfg_n=MAX_N+1 -> same.
- N=3, M=4, second start pulse at cycle 5 -> ignored; exactly 4 writes at addr 0..3, single done at cycle 25.
- rst asserted at cycle 10 of an N=3, M=4 run -> outputs 0 asynchronously, state IDLE. A fresh start then completes normally.
